rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 32-entry register file's single write port. It accepts write requests from up to `NUM_REQ` producers (ALU, load unit, CSR unit) over valid/ready handshakes and grants one at a time in round-robin order. It drives the register file's write-enable, address and data, then waits for the register file's write-done status before granting again. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..4)
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width
- `WAIT_TIMEOUT`, 4, WAIT cycles allowed before the done status is declared missing (1..15)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `req_valid`  in  NUM_REQ  per-requester write request
- `req_addr`  in  NUM_REQ*ADDR_W  flattened destination registers; requester i uses slice i
- `req_data`  in  NUM_REQ*DATA_W  flattened write data; requester i uses slice i
- `req_ready`  out  NUM_REQ  one-hot accept; combinational from state and `req_valid`
- `ctrl_reg_write_enable`  out  1  register file write enable
- `write_reg`  out  ADDR_W  register file write address
- `write_data`  out  DATA_W  register file write data
- `stat_reg_write_done`  in  1  register file write-done status
- `stat_busy`  out  1  high whenever state ≠ IDLE
- `stat_grant_id`  out  2  index of the last granted requester
- `stat_timeout_err`  out  1  sticky; done status missing
- `stat_write_count`  out  16  completed writes, wraps

## Operation
- The FSM has three states: IDLE, WRITE and WAIT. The state, grant pointer, latched address/data, timeout counter, error flag and write count are registers.
- IDLE:
  - If any `req_valid` is high, pick the first valid requester searching from `last_grant+1` mod NUM_REQ upward.
  - Assert `req_ready` for that requester only. The transfer occurs on that edge.
  - Latch its address and data into `write_reg`/`write_data`, set `last_grant`/`stat_grant_id`, and go to WRITE.
- WRITE:
  - `ctrl_reg_write_enable`=1 (decoded from the state register, so exactly one cycle).
  - Go to WAIT, clearing the timeout counter.
- WAIT:
  - If `stat_reg_write_done`=1: increment `stat_write_count` and go to IDLE.
  - Otherwise increment the counter. When the counter reaches WAIT_TIMEOUT, set `stat_timeout_err` and go to IDLE without counting the write.
- `stat_reg_write_done` is ignored outside WAIT.
- `req_ready` is all-zero in WRITE and WAIT. Requesters must hold valid, address and data stable until they see ready.
- `write_reg`/`write_data` hold their last latched value between grants.
- `stat_timeout_err` is cleared only by reset.
- Reset values (immediate on `rst_n` low, including mid-write):
  - state IDLE
  - all outputs 0, `stat_write_count` 0
  - `last_grant` = NUM_REQ-1, so requester 0 wins first
  - An in-flight write is abandoned; the enable drops asynchronously.

## Timing
- The accept edge ends cycle T0 (IDLE).
- Enable is high in T1.
- The register file samples at the end of T1 and asserts done in T2.
- FSM returns to IDLE at the end of T2.
- The next accept is possible in T3. Steady-state throughput is one write per 3 cycles.
- With continuous requests from all three requesters, the grant order is 0,1,2,0,… One requester never wins twice while another is waiting.
- Done arriving on the same edge as the timeout expiry counts as success. No error is set.

## Configuration
- `RF_WB_X0_FILTER_EN` defined:
  - A granted request with address 0 is accepted (ready pulse, pointer advances).
  - The FSM stays in IDLE. No enable is issued and the count is unchanged.
  - `write_reg`/`write_data` are not updated.
- Undefined: address 0 is written like any other register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WRITE → enable drops immediately; after release, all outputs are 0 and requester 0 wins the first grant.
- **Single write:** requester 1 writes addr 5, data 0xDEADBEEF; RF model returns done one cycle after enable → enable high exactly one cycle with `write_reg`=5 and `write_data`=0xDEADBEEF; count=1; ready again 3 cycles after accept.
- **Round-robin:** all three valid continuously for 9 grants → grant order 0,1,2,0,1,2,0,1,2; count=9.
- **Timeout:** RF model never asserts done → `stat_timeout_err`=1 after 4 WAIT cycles; FSM returns to IDLE; count unchanged; the next request still proceeds.
- **x0 write:** requester 0 writes addr 0, data 0x1234:
  - With `RF_WB_X0_FILTER_EN` → no enable, count unchanged, ready pulsed once.
  - Without it → enable issued with `write_reg`=0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Requester and register-file signal bundle for rf_wb_arbiter.
// master = arbiter view, slave = requesters/register-file view.
interface rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      ctrl_reg_write_enable;
    logic [ADDR_W-1:0]         write_reg;
    logic [DATA_W-1:0]         write_data;
    logic                      stat_reg_write_done;
    logic                      stat_busy;
    logic [1:0]                stat_grant_id;
    logic                      stat_timeout_err;
    logic [15:0]               stat_write_count;

    modport master (
        input  req_valid, req_addr, req_data, stat_reg_write_done,
        output req_ready, ctrl_reg_write_enable, write_reg, write_data,
               stat_busy, stat_grant_id, stat_timeout_err, stat_write_count
    );

    modport slave (
        output req_valid, req_addr, req_data, stat_reg_write_done,
        input  req_ready, ctrl_reg_write_enable, write_reg, write_data,
               stat_busy, stat_grant_id, stat_timeout_err, stat_write_count
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Optional macro RF_WB_X0_FILTER_EN: accept but drop writes to register x0.
module rf_wb_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int WAIT_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          last_grant;
    logic [1:0]          grant_id;
    logic [ADDR_W-1:0]   write_reg_q;
    logic [DATA_W-1:0]   write_data_q;
    logic [3:0]          wait_cnt;
    logic                timeout_err;
    logic [15:0]         write_count;

    logic                pick_found;
    logic [1:0]          pick_idx;
    logic [1:0]          cand;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_data;
    logic                accept;
    logic                launch;
    logic                write_ok;
    logic                write_lost;

    // Search starts one past the previous winner so nobody wins twice while another waits.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = 2'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign pick_addr = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign pick_data = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = '0;
        accept        = 1'b0;
        launch        = 1'b0;
        write_ok      = 1'b0;
        write_lost    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    bus.req_ready[pick_idx] = 1'b1;
                    accept                  = 1'b1;
`ifdef RF_WB_X0_FILTER_EN
                    launch                  = (pick_addr != '0);
`else
                    launch                  = 1'b1;
`endif
                    if (launch) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                state_next = WAIT;
            end
            WAIT: begin
                // Done on the expiry cycle still wins over the timeout.
                if (bus.stat_reg_write_done) begin
                    write_ok   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == 4'(WAIT_TIMEOUT - 1)) begin
                    write_lost = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= 2'(NUM_REQ - 1);
            grant_id     <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            wait_cnt     <= '0;
            timeout_err  <= 1'b0;
            write_count  <= '0;
        end else begin
            if (accept) begin
                last_grant <= pick_idx;
                grant_id   <= pick_idx;
            end
            if (launch) begin
                write_reg_q  <= pick_addr;
                write_data_q <= pick_data;
            end
            if (state == WRITE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (write_ok) begin
                write_count <= write_count + 16'd1;
            end
            if (write_lost) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign bus.ctrl_reg_write_enable = (state == WRITE);
    assign bus.stat_busy             = (state != IDLE);
    assign bus.write_reg             = write_reg_q;
    assign bus.write_data            = write_data_q;
    assign bus.stat_grant_id         = grant_id;
    assign bus.stat_timeout_err      = timeout_err;
    assign bus.stat_write_count      = write_count;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed requests push expected writes,
// a monitor pops and compares each register-file write as it appears.
module tb_rf_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        id;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rf_respond;
    logic en_prev;
    logic en_last;
    int   assertions;
    int   failures;
    exp_t exp_q[$];

    rf_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .WAIT_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Register-file model: done is raised for the cycle after the enable cycle.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stat_reg_write_done = 1'b0;
            en_prev                 = 1'b0;
        end else begin
            bus.stat_reg_write_done = en_prev;
            en_prev                 = bus.ctrl_reg_write_enable && rf_respond;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.ctrl_reg_write_enable) begin
            exp_t e;
            checkOutput("enable_one_cycle", {31'd0, en_last}, 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_reg", 32'(bus.write_reg), 32'(e.addr));
                checkOutput("write_data", bus.write_data, e.data);
                checkOutput("grant_id", 32'(bus.stat_grant_id), 32'(e.id));
            end
        end
        en_last = rst_n && bus.ctrl_reg_write_enable;
    end

    task automatic setReq(input int id, input logic valid, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus.req_valid[id]                   = valid;
        bus.req_addr[id*ADDR_W +: ADDR_W]   = addr;
        bus.req_data[id*DATA_W +: DATA_W]   = data;
    endtask

    // Raise a request, wait for its ready, drop valid after the accept edge (returns in T1).
    task automatic applyStimulus(input int id, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data, input bit push);
        bit got;
        exp_t e;
        @(negedge clk);
        setReq(id, 1'b1, addr, data);
        if (push) begin
            e.addr = addr;
            e.data = data;
            e.id   = 2'(id);
            exp_q.push_back(e);
        end
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (bus.req_ready[id]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("ready_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic waitCount(input int target);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.stat_write_count == 16'(target)) begin
                hit = 1'b1;
                break;
            end
        end
        checkOutput("write_count_reached", 32'(bus.stat_write_count), 32'(target));
    endtask

    task automatic checkResetState();
        checkOutput("rst_enable", {31'd0, bus.ctrl_reg_write_enable}, 32'd0);
        checkOutput("rst_write_reg", 32'(bus.write_reg), 32'd0);
        checkOutput("rst_write_data", bus.write_data, 32'd0);
        checkOutput("rst_busy", {31'd0, bus.stat_busy}, 32'd0);
        checkOutput("rst_grant_id", 32'(bus.stat_grant_id), 32'd0);
        checkOutput("rst_timeout_err", {31'd0, bus.stat_timeout_err}, 32'd0);
        checkOutput("rst_write_count", 32'(bus.stat_write_count), 32'd0);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepts;
        exp_t e;
        assertions      = 0;
        failures        = 0;
        en_last         = 1'b0;
        rf_respond      = 1'b1;
        rst_n           = 1'b0;
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkResetState();

        // Single write from requester 1, then a back-to-back second write.
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 1'b1);
        checkOutput("t1_enable", {31'd0, bus.ctrl_reg_write_enable}, 32'd1);
        setReq(1, 1'b1, 5'd6, 32'hCAFEF00D);
        e.addr = 5'd6;
        e.data = 32'hCAFEF00D;
        e.id   = 2'd1;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        checkOutput("t1_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t2_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("t2_busy", {31'd0, bus.stat_busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t3_ready", 32'(bus.req_ready), 32'b010);
        checkOutput("t3_count", 32'(bus.stat_write_count), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        waitCount(2);

        // Reset in the middle of a write: enable must fall without a clock.
        applyStimulus(2, 5'd3, 32'h00000055, 1'b0);
        checkOutput("pre_rst_enable", {31'd0, bus.ctrl_reg_write_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_enable", {31'd0, bus.ctrl_reg_write_enable}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkResetState();

        // All three requesters hold valid for nine grants.
        for (int r = 0; r < 9; r++) begin
            e.addr = 5'(10 + (r % 3));
            e.data = 32'hA0000000 + 32'(r % 3);
            e.id   = 2'(r % 3);
            exp_q.push_back(e);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) setReq(i, 1'b1, 5'(10 + i), 32'hA0000000 + 32'(i));
        accepts = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (|bus.req_ready) accepts++;
            if (accepts == 9) begin
                @(posedge clk);
                #1;
                bus.req_valid = '0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rr_accepts", 32'(accepts), 32'd9);
        waitCount(9);

        // Register file never answers: timeout after four WAIT cycles.
        rf_respond = 1'b0;
        applyStimulus(2, 5'd7, 32'h0BADF00D, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("to_t5_busy", {31'd0, bus.stat_busy}, 32'd1);
        checkOutput("to_t5_err", {31'd0, bus.stat_timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("to_err", {31'd0, bus.stat_timeout_err}, 32'd1);
        checkOutput("to_idle", {31'd0, bus.stat_busy}, 32'd0);
        checkOutput("to_count", 32'(bus.stat_write_count), 32'd9);
        rf_respond = 1'b1;
        applyStimulus(1, 5'd8, 32'h11112222, 1'b1);
        waitCount(10);
        checkOutput("to_err_sticky", {31'd0, bus.stat_timeout_err}, 32'd1);

        // Write to x0 from requester 0.
`ifdef RF_WB_X0_FILTER_EN
        applyStimulus(0, 5'd0, 32'h00001234, 1'b0);
        checkOutput("x0_busy", {31'd0, bus.stat_busy}, 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("x0_count", 32'(bus.stat_write_count), 32'd10);
        checkOutput("x0_write_reg", 32'(bus.write_reg), 32'd8);
`else
        applyStimulus(0, 5'd0, 32'h00001234, 1'b1);
        checkOutput("x0_busy", {31'd0, bus.stat_busy}, 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("x0_count", 32'(bus.stat_write_count), 32'd11);
        checkOutput("x0_write_reg", 32'(bus.write_reg), 32'd0);
`endif
        checkOutput("x0_grant_id", 32'(bus.stat_grant_id), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
